// File: rtl/memory_stage_pipe.sv
// memory_stage_pipe: MEM stage between EX/MEM and MEM/WB.
// Drives a request/response data-memory port, stalls the pipeline while a
// load is outstanding, and registers the MEM/WB bundle every cycle.
// Ports:
//   clk, rst (async, active-low)
//   M-stage bundle : valid_m, RegWriteM, MemWriteM, MemReadM, ResultSrcM,
//                    funct3_m, RD_M, PCPlus4M, WriteDataM, ALU_ResultM
//   stall_m        : hold all M-stage inputs while high
//   memory request : mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, mem_gnt
//   memory response: mem_rvalid, mem_rdata, mem_s_err, mem_d_err
//   W-stage bundle : valid_w, RegWriteW, ResultSrcW, RD_W, PCPlus4W,
//                    ALU_ResultW, ReadDataW, misalign_w, bus_err_w, d_err_w
//   s_err_cnt      : saturating count of corrected load errors
module memory_stage_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_m,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              MemReadM,
  input  logic              ResultSrcM,
  input  logic [2:0]        funct3_m,
  input  logic [4:0]        RD_M,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [XLEN-1:0]   WriteDataM,
  input  logic [XLEN-1:0]   ALU_ResultM,
  output logic              stall_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_s_err,
  input  logic              mem_d_err,
  output logic              valid_w,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [4:0]        RD_W,
  output logic [XLEN-1:0]   PCPlus4W,
  output logic [XLEN-1:0]   ALU_ResultW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic              misalign_w,
  output logic              bus_err_w,
  output logic              d_err_w,
  output logic [CNT_W-1:0]  s_err_cnt
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OB = $clog2(NB);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [XLEN-1:0] ONES = '1;

  typedef enum logic {IDLE, WAIT_R} state_t;

  state_t          state;
  logic [TW-1:0]   cnt;

  logic [OB-1:0]   off;
  int unsigned     sz_i;
  int unsigned     off_i;
  logic            misal_addr;
  logic            is_mem;
  logic            misalign;
  logic            mem_op;
  logic [XLEN-1:0] size_mask;
  logic [XLEN-1:0] rep;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] sbit_vec;
  logic            fill;
  logic [XLEN-1:0] load_data;
  logic            timeout_hit;
  logic            resp;
  logic            bus_err;
  logic            d_err;
  logic            complete;

  assign off = ALU_ResultM[OB-1:0];

  always_comb begin
    sz_i       = 32'd1 << funct3_m[1:0];
    off_i      = 32'(off);
    misal_addr = (sz_i > NB) || ((off_i & (sz_i - 32'd1)) != 32'd0);
    is_mem     = valid_m & (MemReadM | MemWriteM);
    misalign   = is_mem & misal_addr;
    mem_op     = is_mem & ~misal_addr;

    // Shifting by >= XLEN yields zero, so a full-width access gets an all-ones mask.
    size_mask  = ~(ONES << (8 * sz_i));

    // Store lane data: low sz bytes replicated at every sz-aligned lane.
    rep        = WriteDataM & size_mask;
    mem_wdata  = rep;
    for (int unsigned k = 1; k < NB; k++) begin
      if ((k % sz_i) == 0)
        mem_wdata = mem_wdata | (rep << (8 * k));
    end
    mem_wstrb  = NB'(((32'd1 << sz_i) - 32'd1) << off_i);
    mem_addr   = {ALU_ResultM[XLEN-1:OB], {OB{1'b0}}};
    mem_we     = MemWriteM;
    mem_req    = (state == IDLE) & mem_op;

    // Load extraction: align the field to bit 0, then sign/zero-extend.
    shifted    = mem_rdata >> (8 * off_i);
    sbit_vec   = shifted >> (8 * sz_i - 1);
    fill       = sbit_vec[0] & ~funct3_m[2];
    load_data  = (shifted & size_mask) | (fill ? ~size_mask : '0);

    timeout_hit = (cnt == TW'(TIMEOUT - 1));
    resp        = (state == WAIT_R) & mem_rvalid;
    bus_err     = (state == WAIT_R) & ~mem_rvalid & timeout_hit;
    d_err       = resp & mem_d_err;

    if (state == IDLE)
      complete = ~mem_op | (MemWriteM & mem_gnt);
    else
      complete = mem_rvalid | timeout_hit;
    stall_m = ~complete;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      valid_w     <= 1'b0;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      misalign_w  <= 1'b0;
      bus_err_w   <= 1'b0;
      d_err_w     <= 1'b0;
      s_err_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (mem_op & MemReadM & mem_gnt)
            state <= WAIT_R;
        end
        WAIT_R: begin
          if (complete) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      if (complete) begin
        valid_w     <= valid_m;
        RegWriteW   <= RegWriteM & ~misalign & ~bus_err & ~d_err;
        ResultSrcW  <= ResultSrcM;
        RD_W        <= RD_M;
        PCPlus4W    <= PCPlus4M;
        ALU_ResultW <= ALU_ResultM;
        ReadDataW   <= (resp & MemReadM) ? load_data : '0;
        misalign_w  <= misalign;
        bus_err_w   <= bus_err;
        d_err_w     <= d_err;
      end else begin
        // Bubble: payload fields keep their previous values.
        valid_w    <= 1'b0;
        RegWriteW  <= 1'b0;
        misalign_w <= 1'b0;
        bus_err_w  <= 1'b0;
        d_err_w    <= 1'b0;
      end

      if (resp & mem_s_err & (s_err_cnt != '1))
        s_err_cnt <= s_err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_memory_stage_pipe.sv
// tb_memory_stage_pipe: directed self-checking bench for memory_stage_pipe.
// dut32: XLEN=32, TIMEOUT=4, CNT_W=2 (short timeout, quick saturation).
// dut64: XLEN=64 default TIMEOUT/CNT_W, used for double-word lanes.
module tb_memory_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid_m, valid_m64;
  logic        RegWriteM, MemWriteM, MemReadM, ResultSrcM;
  logic [2:0]  funct3_m;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM, mem_rdata;
  logic [63:0] PCPlus4M64, WriteDataM64, ALU_ResultM64, mem_rdata64;
  logic        mem_gnt, mem_rvalid, mem_s_err, mem_d_err;

  logic        stall_m, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        valid_w, RegWriteW, ResultSrcW, misalign_w, bus_err_w, d_err_w;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
  logic [1:0]  s_err_cnt;

  logic        stall_m64, mem_req64, mem_we64;
  logic [63:0] mem_addr64, mem_wdata64;
  logic [7:0]  mem_wstrb64;
  logic        valid_w64, RegWriteW64, ResultSrcW64, misalign_w64, bus_err_w64, d_err_w64;
  logic [4:0]  RD_W64;
  logic [63:0] PCPlus4W64, ALU_ResultW64, ReadDataW64;
  logic [15:0] s_err_cnt64;

  int checks = 0;
  int failures = 0;

  memory_stage_pipe #(.XLEN(32), .TIMEOUT(4), .CNT_W(2)) dut32 (
    .clk(clk), .rst(rst), .valid_m(valid_m), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM), .ResultSrcM(ResultSrcM),
    .funct3_m(funct3_m), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_s_err(mem_s_err),
    .mem_d_err(mem_d_err), .valid_w(valid_w), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .RD_W(RD_W), .PCPlus4W(PCPlus4W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .misalign_w(misalign_w),
    .bus_err_w(bus_err_w), .d_err_w(d_err_w), .s_err_cnt(s_err_cnt)
  );

  memory_stage_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .valid_m(valid_m64), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM), .ResultSrcM(ResultSrcM),
    .funct3_m(funct3_m), .RD_M(RD_M), .PCPlus4M(PCPlus4M64),
    .WriteDataM(WriteDataM64), .ALU_ResultM(ALU_ResultM64), .stall_m(stall_m64),
    .mem_req(mem_req64), .mem_we(mem_we64), .mem_addr(mem_addr64),
    .mem_wstrb(mem_wstrb64), .mem_wdata(mem_wdata64), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata64), .mem_s_err(mem_s_err),
    .mem_d_err(mem_d_err), .valid_w(valid_w64), .RegWriteW(RegWriteW64),
    .ResultSrcW(ResultSrcW64), .RD_W(RD_W64), .PCPlus4W(PCPlus4W64),
    .ALU_ResultW(ALU_ResultW64), .ReadDataW(ReadDataW64), .misalign_w(misalign_w64),
    .bus_err_w(bus_err_w64), .d_err_w(d_err_w64), .s_err_cnt(s_err_cnt64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_m = 1'b0; valid_m64 = 1'b0;
    RegWriteM = 1'b0; MemWriteM = 1'b0; MemReadM = 1'b0; ResultSrcM = 1'b0;
    funct3_m = 3'b000;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_s_err = 1'b0; mem_d_err = 1'b0;
  endtask

  task automatic set_op(input logic v, input logic rw, input logic mw, input logic mr,
                        input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wd);
    valid_m = v; valid_m64 = 1'b0;
    RegWriteM = rw; MemWriteM = mw; MemReadM = mr; ResultSrcM = mr;
    funct3_m = f3; RD_M = 5'd9;
    ALU_ResultM = addr[31:0]; ALU_ResultM64 = addr;
    WriteDataM = wd[31:0]; WriteDataM64 = wd;
    PCPlus4M = addr[31:0] + 32'd4; PCPlus4M64 = addr + 64'd4;
  endtask

  // Load with immediate grant and a response in the first WAIT_R cycle.
  task automatic do_load(input logic sel64, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] rdata, input logic serr, input logic derr);
    set_op(~sel64, 1'b1, 1'b0, 1'b1, f3, addr, 64'd0);
    valid_m64 = sel64;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1;
    mem_rdata = rdata[31:0]; mem_rdata64 = rdata;
    mem_s_err = serr; mem_d_err = derr;
    step();
    idle();
  endtask

  task automatic test_reset();
    #12;
    checks++; if (valid_w !== 1'b0) begin failures++; $display("FAIL rst_valid_w got=%b exp=0", valid_w); end
    checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL rst_regwrite got=%b exp=0", RegWriteW); end
    checks++; if (ReadDataW !== 32'd0) begin failures++; $display("FAIL rst_readdata got=%h exp=0", ReadDataW); end
    checks++; if (s_err_cnt !== 2'd0) begin failures++; $display("FAIL rst_serr_cnt got=%0d exp=0", s_err_cnt); end
    checks++; if (stall_m !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall_m); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_store_word();
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 64'h100, 64'hDEADBEEF);
    mem_gnt = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL sw_req got=%b exp=1", mem_req); end
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL sw_we got=%b exp=1", mem_we); end
    checks++; if (mem_wstrb !== 4'hF) begin failures++; $display("FAIL sw_wstrb got=%h exp=f", mem_wstrb); end
    checks++; if (mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", mem_wdata); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL sw_addr got=%h exp=100", mem_addr); end
    checks++; if (stall_m !== 1'b0) begin failures++; $display("FAIL sw_stall got=%b exp=0", stall_m); end
    step();
    idle();
    checks++; if (valid_w !== 1'b1) begin failures++; $display("FAIL sw_valid_w got=%b exp=1", valid_w); end
    checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL sw_regwrite got=%b exp=0", RegWriteW); end
  endtask

  task automatic test_subword();
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 64'h103, 64'h123456A5);
    mem_gnt = 1'b1;
    #1;
    checks++; if (mem_wstrb !== 4'b1000) begin failures++; $display("FAIL sb_wstrb got=%b exp=1000", mem_wstrb); end
    checks++; if (mem_wdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", mem_wdata); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL sb_addr got=%h exp=100", mem_addr); end
    step();
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 64'h102, 64'h0000BEEF);
    mem_gnt = 1'b1;
    #1;
    checks++; if (mem_wstrb !== 4'b1100) begin failures++; $display("FAIL sh_wstrb got=%b exp=1100", mem_wstrb); end
    checks++; if (mem_wdata !== 32'hBEEFBEEF) begin failures++; $display("FAIL sh_wdata got=%h exp=beefbeef", mem_wdata); end
    step();
    idle();
    do_load(1'b0, 3'b000, 64'h103, 64'hA5000000, 1'b0, 1'b0);
    checks++; if (ReadDataW !== 32'hFFFFFFA5) begin failures++; $display("FAIL lb_data got=%h exp=ffffffa5", ReadDataW); end
    checks++; if (RegWriteW !== 1'b1) begin failures++; $display("FAIL lb_regwrite got=%b exp=1", RegWriteW); end
    do_load(1'b0, 3'b100, 64'h103, 64'hA5000000, 1'b0, 1'b0);
    checks++; if (ReadDataW !== 32'h000000A5) begin failures++; $display("FAIL lbu_data got=%h exp=000000a5", ReadDataW); end
    do_load(1'b0, 3'b001, 64'h102, 64'h80010000, 1'b0, 1'b0);
    checks++; if (ReadDataW !== 32'hFFFF8001) begin failures++; $display("FAIL lh_data got=%h exp=ffff8001", ReadDataW); end
  endtask

  task automatic test_wait_load();
    int stalls = 0;
    int pulses = 0;
    int bubble_bad = 0;
    logic [31:0] rd = '0;
    logic rwv = 1'b0;
    logic [4:0] rdw = '0;
    set_op(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 64'h200, 64'd0);
    mem_rdata = 32'h12345678;
    for (int c = 0; c < 8; c++) begin
      if (c >= 6) idle();
      else begin
        mem_gnt = (c == 2);
        mem_rvalid = (c == 5);
      end
      #1;
      if (stall_m === 1'b1) stalls++;
      step();
      if (valid_w === 1'b1) begin
        pulses++; rd = ReadDataW; rwv = RegWriteW; rdw = RD_W;
      end else if (RegWriteW !== 1'b0) bubble_bad++;
    end
    checks++; if (stalls != 5) begin failures++; $display("FAIL lw_stall_cycles got=%0d exp=5", stalls); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL lw_valid_pulses got=%0d exp=1", pulses); end
    checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL lw_data got=%h exp=12345678", rd); end
    checks++; if (rwv !== 1'b1) begin failures++; $display("FAIL lw_regwrite got=%b exp=1", rwv); end
    checks++; if (rdw !== 5'd9) begin failures++; $display("FAIL lw_rd got=%0d exp=9", rdw); end
    checks++; if (bubble_bad != 0) begin failures++; $display("FAIL lw_bubble_regwrite got=%0d exp=0", bubble_bad); end
  endtask

  task automatic test_misalign();
    set_op(1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 64'h101, 64'd0);
    mem_gnt = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL lh_mis_req got=%b exp=0", mem_req); end
    checks++; if (stall_m !== 1'b0) begin failures++; $display("FAIL lh_mis_stall got=%b exp=0", stall_m); end
    step();
    checks++; if (misalign_w !== 1'b1) begin failures++; $display("FAIL lh_mis_flag got=%b exp=1", misalign_w); end
    checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL lh_mis_regwrite got=%b exp=0", RegWriteW); end
    checks++; if (valid_w !== 1'b1) begin failures++; $display("FAIL lh_mis_valid got=%b exp=1", valid_w); end
    set_op(1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 64'h100, 64'd0);
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL ld32_req got=%b exp=0", mem_req); end
    step();
    idle();
    checks++; if (misalign_w !== 1'b1) begin failures++; $display("FAIL ld32_mis_flag got=%b exp=1", misalign_w); end
  endtask

  task automatic test_timeout();
    set_op(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 64'h300, 64'd0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (stall_m !== (k < 4)) begin failures++; $display("FAIL to_stall_%0d got=%b exp=%b", k, stall_m, (k < 4)); end
      step();
    end
    checks++; if (valid_w !== 1'b1) begin failures++; $display("FAIL to_valid got=%b exp=1", valid_w); end
    checks++; if (bus_err_w !== 1'b1) begin failures++; $display("FAIL to_bus_err got=%b exp=1", bus_err_w); end
    checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL to_regwrite got=%b exp=0", RegWriteW); end
    idle();
    mem_rvalid = 1'b1; mem_s_err = 1'b1; mem_d_err = 1'b1;
    #1;
    checks++; if (stall_m !== 1'b0) begin failures++; $display("FAIL stray_stall got=%b exp=0", stall_m); end
    step();
    idle();
    checks++; if (valid_w !== 1'b0) begin failures++; $display("FAIL stray_valid got=%b exp=0", valid_w); end
    checks++; if (d_err_w !== 1'b0) begin failures++; $display("FAIL stray_d_err got=%b exp=0", d_err_w); end
    checks++; if (bus_err_w !== 1'b0) begin failures++; $display("FAIL stray_bus_err got=%b exp=0", bus_err_w); end
    checks++; if (s_err_cnt !== 2'd0) begin failures++; $display("FAIL stray_serr_cnt got=%0d exp=0", s_err_cnt); end
  endtask

  task automatic test_ecc();
    do_load(1'b0, 3'b010, 64'h400, 64'h11112222, 1'b1, 1'b0);
    checks++; if (s_err_cnt !== 2'd1) begin failures++; $display("FAIL ecc_cnt1 got=%0d exp=1", s_err_cnt); end
    checks++; if (ReadDataW !== 32'h11112222) begin failures++; $display("FAIL ecc_s_data got=%h exp=11112222", ReadDataW); end
    do_load(1'b0, 3'b010, 64'h400, 64'h11112222, 1'b1, 1'b0);
    do_load(1'b0, 3'b010, 64'h400, 64'h11112222, 1'b1, 1'b0);
    checks++; if (s_err_cnt !== 2'd3) begin failures++; $display("FAIL ecc_cnt3 got=%0d exp=3", s_err_cnt); end
    checks++; if (RegWriteW !== 1'b1) begin failures++; $display("FAIL ecc_s_regwrite got=%b exp=1", RegWriteW); end
    do_load(1'b0, 3'b010, 64'h400, 64'h33334444, 1'b0, 1'b1);
    checks++; if (d_err_w !== 1'b1) begin failures++; $display("FAIL ecc_d_err got=%b exp=1", d_err_w); end
    checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL ecc_d_regwrite got=%b exp=0", RegWriteW); end
    checks++; if (valid_w !== 1'b1) begin failures++; $display("FAIL ecc_d_valid got=%b exp=1", valid_w); end
    checks++; if (s_err_cnt !== 2'd3) begin failures++; $display("FAIL ecc_d_cnt got=%0d exp=3", s_err_cnt); end
    do_load(1'b0, 3'b010, 64'h400, 64'h33334444, 1'b1, 1'b1);
    checks++; if (s_err_cnt !== 2'd3) begin failures++; $display("FAIL ecc_sat got=%0d exp=3", s_err_cnt); end
    checks++; if (d_err_w !== 1'b1) begin failures++; $display("FAIL ecc_both_d_err got=%b exp=1", d_err_w); end
  endtask

  task automatic test_dword();
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 64'h8, 64'h0123456789ABCDEF);
    valid_m64 = 1'b1;
    mem_gnt = 1'b1;
    #1;
    checks++; if (mem_wstrb64 !== 8'hFF) begin failures++; $display("FAIL sd_wstrb got=%h exp=ff", mem_wstrb64); end
    checks++; if (mem_wdata64 !== 64'h0123456789ABCDEF) begin failures++; $display("FAIL sd_wdata got=%h exp=0123456789abcdef", mem_wdata64); end
    checks++; if (mem_req64 !== 1'b1) begin failures++; $display("FAIL sd_req got=%b exp=1", mem_req64); end
    step();
    idle();
    checks++; if (valid_w64 !== 1'b1) begin failures++; $display("FAIL sd_valid got=%b exp=1", valid_w64); end
    do_load(1'b1, 3'b011, 64'h8, 64'hFEDCBA9876543210, 1'b0, 1'b0);
    checks++; if (ReadDataW64 !== 64'hFEDCBA9876543210) begin failures++; $display("FAIL ld_data got=%h exp=fedcba9876543210", ReadDataW64); end
    do_load(1'b1, 3'b010, 64'hC, 64'h8000000000000000, 1'b0, 1'b0);
    checks++; if (ReadDataW64 !== 64'hFFFFFFFF80000000) begin failures++; $display("FAIL lw64_data got=%h exp=ffffffff80000000", ReadDataW64); end
    do_load(1'b1, 3'b110, 64'hC, 64'h8000000000000000, 1'b0, 1'b0);
    checks++; if (ReadDataW64 !== 64'h0000000080000000) begin failures++; $display("FAIL lwu64_data got=%h exp=0000000080000000", ReadDataW64); end
    do_load(1'b1, 3'b000, 64'hF, 64'h8000000000000000, 1'b1, 1'b1);
    checks++; if (ReadDataW64 !== 64'hFFFFFFFFFFFFFF80) begin failures++; $display("FAIL lb64_data got=%h exp=ffffffffffffff80", ReadDataW64); end
    checks++; if (s_err_cnt64 !== 16'd1) begin failures++; $display("FAIL lb64_serr_cnt got=%0d exp=1", s_err_cnt64); end
    checks++; if (d_err_w64 !== 1'b1) begin failures++; $display("FAIL lb64_d_err got=%b exp=1", d_err_w64); end
    checks++; if (RegWriteW64 !== 1'b0) begin failures++; $display("FAIL lb64_regwrite got=%b exp=0", RegWriteW64); end
    checks++; if (s_err_cnt !== 2'd3) begin failures++; $display("FAIL dw_cnt32_kept got=%0d exp=3", s_err_cnt); end
  endtask

  task automatic test_reset_mid();
    set_op(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 64'h500, 64'd0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    #1;
    checks++; if (stall_m !== 1'b1) begin failures++; $display("FAIL mid_stall got=%b exp=1", stall_m); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (valid_w !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", valid_w); end
    checks++; if (PCPlus4W !== 32'd0) begin failures++; $display("FAIL mid_pc got=%h exp=0", PCPlus4W); end
    checks++; if (ReadDataW !== 32'd0) begin failures++; $display("FAIL mid_readdata got=%h exp=0", ReadDataW); end
    checks++; if (RD_W !== 5'd0) begin failures++; $display("FAIL mid_rd got=%0d exp=0", RD_W); end
    checks++; if (d_err_w !== 1'b0) begin failures++; $display("FAIL mid_d_err got=%b exp=0", d_err_w); end
    checks++; if (s_err_cnt !== 2'd0) begin failures++; $display("FAIL mid_serr_cnt got=%0d exp=0", s_err_cnt); end
    checks++; if (d_err_w64 !== 1'b0) begin failures++; $display("FAIL mid_d_err64 got=%b exp=0", d_err_w64); end
    idle();
    #1;
    checks++; if (stall_m !== 1'b0) begin failures++; $display("FAIL mid_idle_stall got=%b exp=0", stall_m); end
    rst = 1'b1;
    step();
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 64'h600, 64'd0);
    #1;
    checks++; if (stall_m !== 1'b0) begin failures++; $display("FAIL post_rst_stall got=%b exp=0", stall_m); end
    step();
    idle();
    checks++; if (valid_w !== 1'b1) begin failures++; $display("FAIL post_rst_valid got=%b exp=1", valid_w); end
    checks++; if (RegWriteW !== 1'b1) begin failures++; $display("FAIL post_rst_regwrite got=%b exp=1", RegWriteW); end
    checks++; if (ALU_ResultW !== 32'h600) begin failures++; $display("FAIL post_rst_alu got=%h exp=600", ALU_ResultW); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    RD_M = '0; PCPlus4M = '0; WriteDataM = '0; ALU_ResultM = '0; mem_rdata = '0;
    PCPlus4M64 = '0; WriteDataM64 = '0; ALU_ResultM64 = '0; mem_rdata64 = '0;
    test_reset();
    test_store_word();
    test_subword();
    test_wait_load();
    test_misalign();
    test_timeout();
    test_ecc();
    test_dword();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_stage_pipe.md
Name: memory_stage_pipe

Overview:
- Parametrised successor of the MEM stage. It takes the EX/MEM bundle, drives a request/response data-memory port with handshakes, and holds the pipeline (stall_m) while an access is outstanding.
- Adds byte/half/word/double stores via strobes, sign/zero-extending loads, misalignment trap, response timeout, ECC error reporting and a saturating corrected-error counter.
- Drives the MEM/WB register feeding writeback.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; NB = XLEN/8 byte lanes, OB = log2(NB).
- TIMEOUT, 255, max cycles spent in WAIT_R before forced completion; must be ≥ 1.
- CNT_W, 16, width of the corrected-error counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid_m  in  1  M-stage slot holds a real instruction.
- RegWriteM, MemWriteM, MemReadM, ResultSrcM  in  1 each  control bundle.
- funct3_m  in  3  access size/sign: [1:0] = log2(bytes), [2] = unsigned load.
- RD_M  in  5  destination register.
- PCPlus4M, WriteDataM, ALU_ResultM  in  XLEN each  ALU_ResultM is the byte address.
- stall_m  out  1  upstream must hold all M inputs stable while 1.
- mem_req  out  1  request valid. mem_we out 1. mem_addr out XLEN (ALU_ResultM, low OB bits zeroed). mem_wstrb out NB. mem_wdata out XLEN.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1, mem_rdata  in  XLEN, mem_s_err  in  1, mem_d_err  in  1  — load response; s_err/d_err qualified by rvalid.
- valid_w, RegWriteW, ResultSrcW  out  1 each.
- RD_W  out  5. PCPlus4W, ALU_ResultW, ReadDataW  out  XLEN each.
- misalign_w, bus_err_w, d_err_w  out  1 each  per-instruction fault flags, registered with the WB slot.
- s_err_cnt  out  CNT_W  saturating count of corrected (single-bit) load errors.

Behaviour:
- Reset (rst=0, async): FSM → IDLE, timeout counter = 0, all W outputs = 0, flags = 0, s_err_cnt = 0. Reset mid-access abandons the access; the memory side is not notified.
- Size: sz = 1 << funct3_m[1:0]; off = ALU_ResultM[OB-1:0]. Misaligned if (off mod sz) ≠ 0 or sz > NB.
- mem_op = valid_m & (MemReadM | MemWriteM) & ~misaligned. MemReadM and MemWriteM both 1 is illegal input; the bench never drives it.
- FSM IDLE:
  - mem_req = mem_op, combinational from held inputs. mem_we = MemWriteM.
  - mem_wstrb = ((1<<sz)-1) << off.
  - mem_wdata = WriteDataM[8·sz-1:0] replicated across the word.
  - No mem_op: completes this cycle, stall_m = 0.
  - Store with mem_gnt = 1: completes this cycle, stall_m = 0.
  - Store with mem_gnt = 0: stall_m = 1, remain in IDLE, retry next cycle.
  - Load with mem_gnt = 1: → WAIT_R, stall_m = 1.
  - Load with mem_gnt = 0: stall_m = 1, remain in IDLE.
- FSM WAIT_R:
  - mem_req = 0. Counter increments each cycle.
  - mem_rvalid = 1: completes, stall_m = 0, → IDLE, counter cleared.
  - Counter reaches TIMEOUT without rvalid: completes with bus_err_w = 1, → IDLE.
  - Otherwise stall_m = 1.
  - mem_rvalid while in IDLE (late or stray) is ignored.
- Load extraction: byte field = mem_rdata >> (8·off), low 8·sz bits. Sign-extend to XLEN when funct3_m[2] = 0, zero-extend otherwise.
- MEM/WB register, loaded every edge:
  - Completing cycle: valid_w = valid_m. All fields copied from M inputs. ReadDataW = extracted data (0 for non-loads).
  - Fault flags as computed. RegWriteW = RegWriteM & ~misaligned & ~bus_err & ~d_err.
  - Stalled cycle: bubble — valid_w = 0, RegWriteW = 0, flags = 0; other fields don't-care (held).
- Misaligned access with valid_m: no mem_req; completes in one cycle with misalign_w = 1.
- ECC: at a load completion with mem_s_err = 1, s_err_cnt += 1, saturating at all-ones; data used as given (already corrected). mem_d_err = 1 → d_err_w = 1 and write suppressed. Both set → d_err dominates; the counter still increments.
- Latency: non-memory op and granted store take 1 cycle (W valid the next cycle). Load takes grant cycle + response wait + 1.

Test Plan:
- XLEN=32, SW 0xDEADBEEF @0x100, gnt immediate → mem_wstrb = 4'b1111, stall_m = 0, next cycle valid_w = 1, RegWriteW = 0.
- SB 0x...A5 @0x103 → mem_wstrb = 4'b1000, mem_wdata = 0xA5A5A5A5. LB @0x103 with rdata 0xA5000000 → ReadDataW = 0xFFFFFFA5. LBU → 0x000000A5.
- LW @0x200, gnt delayed 2 cycles, rvalid 3 cycles later → stall_m high 5 cycles, exactly one valid_w pulse, ReadDataW = mem_rdata, bubbles show RegWriteW = 0.
- LH @0x101 → no mem_req, misalign_w = 1, RegWriteW = 0. XLEN=64 LD @0x8 aligned → wstrb/extraction use the full 8 lanes.
- TIMEOUT=4, LW granted, no rvalid → bus_err_w = 1 after 4 WAIT_R cycles. A later stray rvalid in IDLE produces no valid_w.
- Loads with s_err ×3, then one with d_err → s_err_cnt = 3, d_err_w = 1, RegWriteW = 0. Assert rst mid WAIT_R → all outputs 0 immediately.
